// File: rtl/riscv_out_capture_pkg.sv
// Shared defaults and entry layout for the RV_CPU output-port capture monitor.
// The timestamp option is selected by the OUT_CAPTURE_TS_EN macro.
package riscv_out_capture_pkg;

  localparam int CAP_DATA_W = 10;
  localparam int CAP_TS_W   = 16;
  localparam int CAP_DEPTH  = 8;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  typedef struct packed {
    logic [CAP_DATA_W-1:0] data;
    logic [CAP_TS_W-1:0]   ts;
  } cap_entry_t;

endpackage

// File: rtl/out_capture_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, and a push
// into a full FIFO is accepted only when a pop frees a slot on the same edge.
module out_capture_fifo #(
  parameter  int W     = 26,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_data
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/riscv_out_capture.sv
// Change-capture monitor on the RV_CPU `out` bus: registers the bus, pushes each
// new value into a FIFO and counts drops. Define OUT_CAPTURE_TS_EN for timestamps.
module riscv_out_capture
  import riscv_out_capture_pkg::*;
#(
  parameter  int DATA_W = CAP_DATA_W,
  parameter  int DEPTH  = CAP_DEPTH,
  parameter  int TS_W   = CAP_TS_W,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              capture_en,
  input  logic              ovf_clr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [TS_W-1:0]   rd_ts,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

`ifdef OUT_CAPTURE_TS_EN
  localparam int EW = DATA_W + TS_W;
  logic [TS_W-1:0] r_ts;
`else
  localparam int EW = DATA_W;
`endif

  // Read port: rd_valid means the head entry is presented; a pop happens on any
  // edge where rd_valid & rd_ready, and the head is held while rd_ready is low.
  logic [DATA_W-1:0] r_in_q;
  logic [DATA_W-1:0] r_last_q;
  logic              r_in_vld;
  logic              r_first;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;
  logic              w_change;
  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;

  // r_in_vld keeps the reset value in r_in_q from being captured as a sample.
  assign w_change   = r_first | (r_in_q != r_last_q);
  assign w_push_req = capture_en & r_in_vld & w_change;
  assign w_pop      = rd_valid & rd_ready;
  assign w_drop     = w_push_req & w_full & ~w_pop;

`ifdef OUT_CAPTURE_TS_EN
  assign w_entry = {r_in_q, r_ts};
  assign rd_ts   = rd_valid ? w_head[TS_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + TS_W'(1);
  end
`else
  assign w_entry = r_in_q;
  assign rd_ts   = '0;
`endif

  out_capture_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count),
    .o_data  (w_head)
  );

  assign rd_valid = ~w_empty;
  assign rd_data  = rd_valid ? w_head[EW-1 -: DATA_W] : '0;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  // last_q follows every push request, so a dropped change is counted once only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_q     <= '0;
      r_in_vld   <= 1'b0;
      r_last_q   <= '0;
      r_first    <= 1'b1;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_in_q   <= cpu_out;
      r_in_vld <= 1'b1;
      if (!capture_en) begin
        r_first <= 1'b1;
      end else if (w_push_req) begin
        r_last_q <= r_in_q;
        r_first  <= 1'b0;
      end
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
      if (w_drop && r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule
